led_scan_controller: RTL and testbench

Sequential column scanner that directly feeds the LED array driver. It drives the column index and the enable line through all N columns with a fixed dwell time and a blanking gap at every column change, so no LED ghosts. It also double-buffers the Conway cell grid and only swaps in a new frame at a frame boundary, so a displayed frame never tears mid-scan.

---
 rtl/led_scan_pkg.sv | 16 +
 rtl/led_scan_controller_timer.sv | 40 ++++
 rtl/led_scan_controller.sv | 151 +++++++++++++++
 tb/tb_led_scan_controller.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED column scanner.
// Holds the scan FSM state type, brightness width and a max helper.
package led_scan_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_t;

  localparam int BRIGHT_W = 5;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_scan_controller_timer.sv
// scan_timer: loadable down-counter with terminal-count flag.
// Ports: clk, rst (async active-low), load/load_val, count, tc (count==0).
module scan_timer #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign tc    = (cnt_q == '0);

endmodule

// File: rtl/led_scan_controller.sv
// LED column scanner: blank/drive per column, double-buffered frame swap.
// Ports: clk, rst (async active-low), frame_in/frame_valid/frame_ready,
//   x, ena, cells, frame_start; brightness when LED_SCAN_BRIGHTNESS_EN.
module led_scan_controller
  import led_scan_pkg::*;
#(
  parameter int N            = 8,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N*N-1:0]        frame_in,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic [$clog2(N):0]    x,
  output logic                  ena,
  output logic [N*N-1:0]        cells,
  output logic                  frame_start
`ifdef LED_SCAN_BRIGHTNESS_EN
  ,
  input  logic [BRIGHT_W-1:0]   brightness
`endif
);

  localparam int PW_RAW = $clog2(max2(DWELL_CYCLES, BLANK_CYCLES));
  localparam int PW     = (PW_RAW < 1) ? 1 : PW_RAW;
  localparam int XW     = $clog2(N) + 1;
  localparam int NN     = N * N;

  localparam logic [PW-1:0] BLANK_LD = PW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] DWELL_LD = PW'(DWELL_CYCLES - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(N - 1);
  localparam logic [XW-1:0] X_ONE    = XW'(1);

  scan_state_t   state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [NN-1:0] cells_q, cells_d;
  logic [NN-1:0] pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic          ready_q, ready_d;

  logic          accept;
  logic          wrap;
  logic          t_load;
  logic [PW-1:0] t_load_val;
  logic [PW-1:0] phase;
  logic          t_tc;

  // Each terminal count flips the state, so the reload value is
  // the length of the state being entered.
  assign t_load     = t_tc;
  assign t_load_val = (state_q == S_BLANK) ? DWELL_LD : BLANK_LD;

  // Reset preloads the blank length so the first column blanks fully.
  scan_timer #(
    .W       (PW),
    .RST_VAL (BLANK_LD)
  ) u_phase (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_load_val),
    .count    (phase),
    .tc       (t_tc)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    cells_d     = cells_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    wrap        = 1'b0;
    accept      = frame_valid && ready_q;
    unique case (state_q)
      S_BLANK: begin
        if (t_tc) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        if (t_tc) begin
          state_d = S_BLANK;
          wrap    = (x_q == X_LAST);
          x_d     = wrap ? '0 : x_q + X_ONE;
        end
      end
    endcase
    if (wrap && pend_full_q) begin
      cells_d     = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d      = frame_in;
      pend_full_d = 1'b1;
    end
    // Ready follows the registered pending flag, so it rises the
    // cycle after a swap empties the buffer.
    ready_d = ~pend_full_q & ~accept;
  end

`ifdef LED_SCAN_BRIGHTNESS_EN
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic [3:0]          phase4;

  always_comb begin
    bright_d = bright_q;
    if (state_q == S_BLANK && t_tc) bright_d = brightness;
  end

  always_comb begin
    phase4 = '0;
    for (int i = 0; i < 4 && i < PW; i++) phase4[i] = phase[i];
  end

  // PWM over each 16-cycle slice of the dwell.
  assign ena = (state_q == S_DRIVE) && ({1'b0, phase4} < bright_q);
`else
  assign ena = (state_q == S_DRIVE);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_BLANK;
      x_q         <= '0;
      cells_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b1;
`ifdef LED_SCAN_BRIGHTNESS_EN
      bright_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      cells_q     <= cells_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      ready_q     <= ready_d;
`ifdef LED_SCAN_BRIGHTNESS_EN
      bright_q    <= bright_d;
`endif
    end
  end

  assign x           = x_q;
  assign cells       = cells_q;
  assign frame_ready = ready_q;
  assign frame_start = (state_q == S_BLANK) && (x_q == '0) &&
                       (phase == BLANK_LD);

endmodule

// File: tb/tb_led_scan_controller.sv
// Self-checking bench for led_scan_controller (N=8, BLANK=2).
// DWELL=10, or 32 with LED_SCAN_BRIGHTNESS_EN for the PWM checks.
`timescale 1ns/1ps
module tb_led_scan_controller;
  import led_scan_pkg::*;

  localparam int N  = 8;
  localparam int BL = 2;
`ifdef LED_SCAN_BRIGHTNESS_EN
  localparam int DW = 32;
`else
  localparam int DW = 10;
`endif
  localparam int CP = BL + DW;
  localparam int FP = N * CP;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N*N-1:0] frame_in = '0;
  logic           frame_valid = 1'b0;
  logic           frame_ready;
  logic [3:0]     x;
  logic           ena;
  logic [N*N-1:0] cells;
  logic           frame_start;
`ifdef LED_SCAN_BRIGHTNESS_EN
  logic [BRIGHT_W-1:0] brightness = '0;
`endif

  always #5 clk = ~clk;

  led_scan_controller #(
    .N            (N),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .x           (x),
    .ena         (ena),
    .cells       (cells),
    .frame_start (frame_start)
`ifdef LED_SCAN_BRIGHTNESS_EN
    ,
    .brightness  (brightness)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          t;
  logic [63:0] m_cells;
  logic [63:0] m_pend;
  bit          m_pv;
  bit          m_ready;
  int          on_cnt;
  int          cur_b;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)",
             tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t       = 0;
    m_cells = '0;
    m_pend  = '0;
    m_pv    = 1'b0;
    m_ready = 1'b1;
    on_cnt  = 0;
    cur_b   = 0;
  endtask

  // Expected timing is pure arithmetic on the cycle index since release.
  task automatic check_all();
    int ph;
    ph = t % CP;
    chk("x", 64'(x), 64'((t / CP) % N));
    chk("frame_start", 64'(frame_start), 64'(t % FP == 0));
    chk("cells", cells, m_cells);
    chk("frame_ready", 64'(frame_ready), 64'(m_ready));
`ifdef LED_SCAN_BRIGHTNESS_EN
    if (ph < BL) chk("ena_blank", 64'(ena), 64'(0));
    else if (ena) on_cnt++;
    if (ph == CP - 1) begin
      chk("ena_duty", 64'(on_cnt), 64'((DW / 16) * cur_b));
      on_cnt = 0;
    end
`else
    chk("ena", 64'(ena), 64'(ph >= BL));
`endif
  endtask

  task automatic advance();
    bit acc;
    bit swp;
`ifdef LED_SCAN_BRIGHTNESS_EN
    if (t % CP == 0) begin
      unique case ((t / CP) % 4)
        0: brightness = 5'd4;
        1: brightness = 5'd0;
        2: brightness = 5'd16;
        default: brightness = 5'($urandom_range(0, 16));
      endcase
      cur_b = int'(brightness);
    end
`endif
    acc = frame_valid && m_ready;
    swp = (t % FP == FP - 1) && m_pv;
    if (swp) begin
      m_cells = m_pend;
      m_pv    = 1'b0;
    end
    if (acc) begin
      m_pend = frame_in;
      m_pv   = 1'b1;
    end
    m_ready = !m_pv && !swp;
    @(posedge clk);
    #1;
    t++;
    check_all();
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", 64'(x), 64'(0));
    chk("rst_ena", 64'(ena), 64'(0));
    chk("rst_cells", cells, 64'(0));
    chk("rst_ready", 64'(frame_ready), 64'(1));
    chk("rst_fstart", 64'(frame_start), 64'(1));

    rst = 1'b1;
    check_all();
    while (t < 20) advance();

    frame_in    = 64'hA5;
    frame_valid = 1'b1;
    advance();
    frame_valid = 1'b0;
    frame_in    = '0;
    chk("ready_drop", 64'(frame_ready), 64'(0));

    while (t < 40) advance();
    frame_in    = 64'h0123_4567_89AB_CDEF;
    frame_valid = 1'b1;
    while (t < FP) advance();
    chk("swap_cells", cells, 64'hA5);
    chk("ready_lag", 64'(frame_ready), 64'(0));
    advance();
    chk("ready_back", 64'(frame_ready), 64'(1));
    advance();
    chk("bp_accept", 64'(frame_ready), 64'(0));
    frame_valid = 1'b0;

    while (t < 3 * FP + 4 * CP) begin
      frame_valid = ($urandom_range(0, 7) == 0);
      frame_in    = {$urandom(), $urandom()};
      advance();
    end
    frame_in    = 64'hDEAD_BEEF_0000_0001;
    frame_valid = 1'b1;
    while (t < 3 * FP + 4 * CP + 2) advance();
    frame_valid = 1'b0;

    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_x", 64'(x), 64'(0));
    chk("mid_rst_ena", 64'(ena), 64'(0));
    chk("mid_rst_cells", cells, 64'(0));
    chk("mid_rst_ready", 64'(frame_ready), 64'(1));
    chk("mid_rst_fstart", 64'(frame_start), 64'(1));

    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    check_all();
    while (t < FP + 2) advance();
    chk("pend_dropped", cells, 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
